// File: rtl/xadc_temp_monitor.sv
// Temperature XADC conversion scheduler: periodic SOC pulses, EOC capture,
// power-of-two averaging and a hysteretic over-temperature flag.
module xadc_temp_monitor #(
    parameter int unsigned SOC_PERIOD = 100000,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned AVG_LOG2   = 4,
    parameter logic [11:0] ALARM_HI   = 12'hB5F,
    parameter logic [11:0] ALARM_LO   = 12'hB0E
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Enable,
    output logic        AdcSoc,
    input  logic        AdcEoc,
    input  logic [11:0] AdcData,
    output logic [11:0] TempAvg,
    output logic        TempValid,
    output logic        OverTemp,
    output logic        Timeout
);

    localparam int unsigned PER_W = (SOC_PERIOD > 1) ? $clog2(SOC_PERIOD) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned ACC_W = 12 + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SOC_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'((2 ** AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_SOC,
        S_WAIT_EOC,
        S_CAPTURE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PER_W-1:0]   r_per_cnt;
    logic               r_tick;
    logic [TO_W-1:0]    r_to_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_smp_cnt;
    logic [11:0]        r_temp_avg;
    logic               r_temp_valid;
    logic               r_over_temp;
    logic               r_timeout;

    logic [ACC_W-1:0]   w_sum;
    logic [11:0]        w_avg;
    logic               w_to_hit;
    logic               w_publish;

    assign w_sum     = r_acc + ACC_W'(AdcData);
    assign w_avg     = 12'(w_sum >> AVG_LOG2);
    assign w_to_hit  = (r_state == S_WAIT_EOC) && !AdcEoc && (r_to_cnt == TO_LAST);
    assign w_publish = (r_state == S_CAPTURE) && (r_smp_cnt == SMP_LAST);

    assign TempAvg   = r_temp_avg;
    assign TempValid = r_temp_valid;
    assign OverTemp  = r_over_temp;
    assign Timeout   = r_timeout;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        AdcSoc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Enable) begin
                    w_next = S_WAIT_TICK;
                end
            end
            S_WAIT_TICK: begin
                if (!Enable) begin
                    w_next = S_IDLE;
                end else if (r_tick) begin
                    w_next = S_SOC;
                end
            end
            S_SOC: begin
                AdcSoc = 1'b1;
                w_next = S_WAIT_EOC;
            end
            S_WAIT_EOC: begin
                // EOC takes priority over the terminal timeout count
                if (AdcEoc) begin
                    w_next = S_CAPTURE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_next = Enable ? S_WAIT_TICK : S_IDLE;
                end
            end
            S_CAPTURE: begin
                w_next = Enable ? S_WAIT_TICK : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Tick is registered so the first SOC lands SOC_PERIOD+1 cycles after enable
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_per_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_per_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (!Enable) begin
            r_tick    <= 1'b0;
        end else begin
            r_tick    <= (r_per_cnt == PER_LAST);
            r_per_cnt <= (r_per_cnt == PER_LAST) ? '0 : r_per_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_to_cnt <= '0;
        end else if (r_state == S_SOC) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_WAIT_EOC) && (r_to_cnt != TO_LAST)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_timeout <= 1'b0;
        end else if (w_to_hit) begin
            r_timeout <= 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_acc        <= '0;
            r_smp_cnt    <= '0;
            r_temp_avg   <= '0;
            r_temp_valid <= 1'b0;
            r_over_temp  <= 1'b0;
        end else begin
            r_temp_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                r_acc     <= '0;
                r_smp_cnt <= '0;
            end else if (w_publish) begin
                r_acc        <= '0;
                r_smp_cnt    <= '0;
                r_temp_avg   <= w_avg;
                r_temp_valid <= 1'b1;
                if (w_avg >= ALARM_HI) begin
                    r_over_temp <= 1'b1;
                end else if (w_avg <= ALARM_LO) begin
                    r_over_temp <= 1'b0;
                end
            end else if (r_state == S_CAPTURE) begin
                r_acc     <= w_sum;
                r_smp_cnt <= r_smp_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xadc_temp_monitor.sv
// Directed bench for xadc_temp_monitor with a simple XADC wrapper model
// (EOC a fixed number of cycles after each SOC, codes taken from a queue).
module tb_xadc_temp_monitor;

    localparam int P  = 50;
    localparam int T  = 20;
    localparam int AL = 2;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Enable;
    logic        AdcSoc;
    logic        AdcEoc;
    logic [11:0] AdcData;
    logic [11:0] TempAvg;
    logic        TempValid;
    logic        OverTemp;
    logic        Timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [11:0] code_q[$];
    int  eoc_delay = 10;
    int  eoc_cd    = 0;
    bit  withhold  = 1'b0;
    bit  spur_req  = 1'b0;

    int  valid_cnt    = 0;
    int  valid_double = 0;
    int  soc_cnt      = 0;
    int  soc_double   = 0;
    bit  prev_valid   = 1'b0;
    bit  prev_soc     = 1'b0;

    xadc_temp_monitor #(
        .SOC_PERIOD (P),
        .TIMEOUT    (T),
        .AVG_LOG2   (AL),
        .ALARM_HI   (12'hB5F),
        .ALARM_LO   (12'hB0E)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Enable    (Enable),
        .AdcSoc    (AdcSoc),
        .AdcEoc    (AdcEoc),
        .AdcData   (AdcData),
        .TempAvg   (TempAvg),
        .TempValid (TempValid),
        .OverTemp  (OverTemp),
        .Timeout   (Timeout)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk) begin
        #1;
        if (TempValid) begin
            valid_cnt++;
            if (prev_valid) valid_double++;
        end
        if (AdcSoc) begin
            soc_cnt++;
            if (prev_soc) soc_double++;
        end
        prev_valid = TempValid;
        prev_soc   = AdcSoc;
    end

    // XADC wrapper model
    initial begin
        AdcEoc  = 1'b0;
        AdcData = '0;
        forever begin
            @(negedge Clk);
            AdcEoc = 1'b0;
            if (spur_req) begin
                AdcEoc   = 1'b1;
                AdcData  = 12'hFFF;
                spur_req = 1'b0;
            end
            if (eoc_cd > 0) begin
                eoc_cd--;
                if (eoc_cd == 0) begin
                    AdcEoc  = 1'b1;
                    AdcData = (code_q.size() > 0) ? code_q.pop_front() : 12'h000;
                end
            end
            if (AdcSoc) begin
                if (withhold) withhold = 1'b0;
                else          eoc_cd   = eoc_delay;
            end
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_soc(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (AdcSoc) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (TempValid) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic push4(input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] c, input logic [11:0] d);
        code_q.push_back(a);
        code_q.push_back(b);
        code_q.push_back(c);
        code_q.push_back(d);
    endtask

    task automatic check_avg(input string tag, input int budget,
                             input logic [11:0] exp_avg, input bit exp_ot);
        int v;
        wait_valid(budget, v);
        check_eq({tag, "_seen"}, int'(v >= 0), 1);
        check_eq({tag, "_avg"}, TempAvg, exp_avg);
        check_eq({tag, "_ot"}, OverTemp, exp_ot);
    endtask

    initial begin
        int c, s, t, v, vc0, sc0;

        // reset and idle
        Rst    = 1'b1;
        Enable = 1'b0;
        tick(3);
        check_eq("rst_soc", AdcSoc, 0);
        check_eq("rst_avg", TempAvg, 0);
        check_eq("rst_valid", TempValid, 0);
        check_eq("rst_ot", OverTemp, 0);
        check_eq("rst_timeout", Timeout, 0);
        Rst = 1'b0;
        tick(200);
        check_eq("idle_soc_cnt", soc_cnt, 0);
        check_eq("idle_valid_cnt", valid_cnt, 0);
        check_eq("idle_avg", TempAvg, 0);

        // averaging and SOC grid
        push4(12'h800, 12'h801, 12'h802, 12'h803);
        c = cyc;
        Enable = 1'b1;
        wait_soc(P + 10, s);
        check_eq("first_soc_cycle", s - (c + 1), P + 1);
        for (int i = 0; i < 3; i++) begin
            wait_soc(P + 5, t);
            check_eq("soc_spacing", t - s, P);
            s = t;
        end
        wait_valid(30, v);
        check_eq("avg_latency", v - s, 12);
        check_eq("avg_value", TempAvg, 12'h801);
        check_eq("avg_ot", OverTemp, 0);
        check_eq("avg_valid_cnt", valid_cnt, 1);

        // hysteresis, with one average at the EOC/timeout boundary
        push4(12'hB5E, 12'hB61, 12'hB60, 12'hB62);
        check_avg("hys_b60", 4 * P + 30, 12'hB60, 1'b1);
        push4(12'hB20, 12'hB20, 12'hB21, 12'hB22);
        check_avg("hys_b20", 4 * P + 30, 12'hB20, 1'b1);
        eoc_delay = T;
        push4(12'hB0E, 12'hB0F, 12'hB0D, 12'hB0E);
        check_avg("hys_b0e", 4 * P + 30, 12'hB0E, 1'b0);
        check_eq("eoc_at_terminal_no_timeout", Timeout, 0);
        eoc_delay = 10;
        push4(12'hB5F, 12'hB5F, 12'hB5F, 12'hB62);
        check_avg("hys_b5f", 4 * P + 30, 12'hB5F, 1'b1);

        // missed EOC, then spurious EOC during WAIT_TICK
        withhold = 1'b1;
        wait_soc(P + 10, s);
        tick(T);
        check_eq("timeout_before", Timeout, 0);
        tick(1);
        check_eq("timeout_rise", Timeout, 1);
        push4(12'hB70, 12'hB70, 12'hB70, 12'hB70);
        wait_soc(P + 5, t);
        check_eq("soc_after_timeout", t - s, P);
        tick(30);
        spur_req = 1'b1;
        wait_valid(4 * P, v);
        check_eq("post_timeout_latency", v - t, 3 * P + 12);
        check_eq("post_timeout_avg", TempAvg, 12'hB70);
        check_eq("timeout_sticky", Timeout, 1);

        // reset pulse during WAIT_EOC
        wait_soc(P + 10, s);
        tick(5);
        Rst = 1'b1;
        tick(2);
        check_eq("midrst_avg", TempAvg, 0);
        check_eq("midrst_ot", OverTemp, 0);
        check_eq("midrst_timeout", Timeout, 0);
        check_eq("midrst_valid", TempValid, 0);
        c = cyc;
        Rst = 1'b0;
        wait_soc(P + 10, t);
        check_eq("soc_after_rst", t - (c + 1), P + 1);
        push4(12'h010, 12'h011, 12'h012, 12'h013);
        wait_valid(4 * P, v);
        check_eq("rst_fresh_latency", v - t, 3 * P + 12);
        check_eq("rst_fresh_avg", TempAvg, 12'h011);

        // Enable drop after two of four samples
        code_q.push_back(12'hA00);
        code_q.push_back(12'hA00);
        code_q.push_back(12'hA00);
        for (int i = 0; i < 3; i++) wait_soc(P + 10, s);
        tick(3);
        Enable = 1'b0;
        vc0 = valid_cnt;
        sc0 = soc_cnt;
        tick(300);
        check_eq("drop_no_valid", valid_cnt - vc0, 0);
        check_eq("drop_no_soc", soc_cnt - sc0, 0);
        push4(12'h123, 12'h124, 12'h125, 12'h126);
        c = cyc;
        Enable = 1'b1;
        wait_soc(P + 10, t);
        check_eq("reenable_soc", t - (c + 1), P + 1);
        wait_valid(4 * P + 20, v);
        check_eq("reenable_latency", v - t, 3 * P + 12);
        check_eq("reenable_avg", TempAvg, 12'h124);

        check_eq("valid_never_double", valid_double, 0);
        check_eq("soc_one_cycle", soc_double, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xadc_temp_monitor.md
# xadc_temp_monitor

Conversion scheduler and post-processor for the on-die temperature XADC wrapper. It issues periodic single-cycle start-of-conversion pulses and captures the 12-bit code after each end-of-conversion. It averages a power-of-two number of samples, publishes the average with a valid strobe, and drives an over-temperature flag with hysteresis. It sits directly in front of and behind the XADC wrapper: it drives `AdcSoc` and consumes `AdcEoc`/`AdcData`.

## Interface
- `SOC_PERIOD`, default 100000: clock cycles between consecutive SOC pulses (1 ms at 100 MHz); must be ≥ `TIMEOUT`+4.
- `TIMEOUT`, default 1024: maximum cycles to wait for EOC after SOC.
- `AVG_LOG2`, default 4: log2 of samples per average (16).
- `ALARM_HI`, default 12'hB5F: set threshold, ≈85 °C.
- `ALARM_LO`, default 12'hB0E: clear threshold, ≈75 °C; must be < `ALARM_HI`.
- `Clk`  in  1  on-board 100 MHz system clock; single clock domain.
- `Rst`  in  1  asynchronous, active-high reset.
- `Enable`  in  1  run monitoring while high.
- `AdcSoc`  out  1  start-of-conversion, one-cycle pulse.
- `AdcEoc`  in  1  end-of-conversion from the XADC wrapper.
- `AdcData`  in  12  registered ADC code; valid the cycle after `AdcEoc`.
- `TempAvg`  out  12  latest averaged code.
- `TempValid`  out  1  one-cycle strobe when `TempAvg` updates.
- `OverTemp`  out  1  hysteretic over-temperature flag.
- `Timeout`  out  1  sticky: an EOC was missed.

## Operation
- FSM states: IDLE, WAIT_TICK, SOC, WAIT_EOC, CAPTURE.
- IDLE:
  - Period counter held at 0; accumulator and sample counter cleared.
  - Go to WAIT_TICK when `Enable`=1.
- Period counter:
  - Counts 0..`SOC_PERIOD`-1 and wraps while `Enable`=1, independent of FSM state.
  - Tick when the counter equals `SOC_PERIOD`-1.
- WAIT_TICK:
  - On tick, go to SOC.
  - If `Enable`=0, go to IDLE.
- SOC: `AdcSoc`=1 for exactly this cycle; timeout counter cleared; go to WAIT_EOC.
- WAIT_EOC:
  - `AdcEoc`=1: go to CAPTURE.
  - Timeout counter reaches `TIMEOUT` with no EOC: set `Timeout`, discard the sample, go to WAIT_TICK.
- CAPTURE:
  - acc ← acc + `AdcData`. acc is 12+`AVG_LOG2` bits wide and cannot overflow.
  - Sample counter increments.
  - On the 2^`AVG_LOG2`-th sample: register `TempAvg` ← (acc+`AdcData`) >> `AVG_LOG2` (truncating), pulse `TempValid`, clear acc and sample counter.
  - Next state: WAIT_TICK if `Enable`=1, else IDLE.
- `Enable` falling mid-conversion: the in-flight conversion completes (EOC or timeout). The FSM then returns to IDLE and the partial sum is discarded.
- `OverTemp` is evaluated only on average update, using the new average:
  - Set when avg ≥ `ALARM_HI`.
  - Cleared when avg ≤ `ALARM_LO`.
  - Held otherwise.
- Ticks that occur outside WAIT_TICK are dropped; no SOC is queued.
- `AdcEoc` outside WAIT_EOC is ignored.
- `Timeout` clears only on `Rst`.

## Timing
- Reset values: `AdcSoc`=0, `TempAvg`=12'h000, `TempValid`=0, `OverTemp`=0, `Timeout`=0. FSM=IDLE; all counters and acc = 0.
- `Rst` asserted mid-operation: immediate return to reset values. Nothing resumes until `Enable` is sampled high after release.
- `Enable` sampled high at edge 0: first `AdcSoc` pulse is at cycle `SOC_PERIOD`+1. Subsequent pulses are exactly `SOC_PERIOD` cycles apart.
- `AdcEoc` high in cycle n: `AdcData` is sampled in cycle n+1 (CAPTURE). `TempValid`, `TempAvg` and `OverTemp` update at the end of n+1 and are visible in n+2.
- Timeout: if no EOC arrives, `Timeout` rises `TIMEOUT`+1 cycles after the `AdcSoc` cycle.
- Simultaneous EOC and timeout-terminal count: EOC wins; the sample is captured and `Timeout` is not set.
- `TempValid` is never high for two consecutive cycles.

## Test plan
All scenarios use `SOC_PERIOD`=50, `TIMEOUT`=20, `AVG_LOG2`=2. The bench XADC model returns EOC 10 cycles after SOC unless stated otherwise.
- Reset and idle: assert `Rst`, hold `Enable`=0 for 200 cycles -> all outputs 0; no `AdcSoc`.
- Averaging: codes 0x800, 0x801, 0x802, 0x803 -> a single `TempValid` with `TempAvg`=0x801; `AdcSoc` pulses are 50 cycles apart, each one cycle wide.
- Hysteresis: averages 0xB60, then 0xB20, then 0xB0E -> `OverTemp` 1, 1, 0. A following 0xB5F average -> 1.
- Timeout: model withholds EOC once -> `Timeout`=1 at SOC+21. The next SOC still arrives on the 50-cycle grid; 4 further good samples are needed for `TempValid`.
- Disturbances:
  - Spurious `AdcEoc` in WAIT_TICK -> no capture.
  - `Rst` pulse during WAIT_EOC -> outputs reset; first SOC is 51 cycles after `Enable` is resampled.
- Enable drop: deassert `Enable` after 2 of 4 samples -> the current conversion completes and no `TempValid` is produced. After re-enable, 4 fresh samples are required for the next `TempAvg`.
